// File: rtl/matrix_display_sequencer.sv
// matrix_display_sequencer: alternates state image and water-level bar on an LED matrix, with forcing, preemption and alarm blink
module matrix_display_sequencer #(
  parameter int COLS        = 5,
  parameter int ROWS        = 7,
  parameter int LEVEL_W     = 3,
  parameter int STATE_DWELL = 50_000_000,
  parameter int LEVEL_DWELL = 25_000_000,
  parameter int BLINK_HALF  = 12_500_000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           current_state,
  input  logic [COLS*ROWS-1:0] state_image,
  input  logic [LEVEL_W-1:0]   water_level,
  input  logic [1:0]           force_mode,
  input  logic                 alarm,
  output logic [COLS*ROWS-1:0] columns,
  output logic                 showing_state
);
  localparam int N    = COLS * ROWS;
  localparam int MAXD = STATE_DWELL > LEVEL_DWELL ? STATE_DWELL : LEVEL_DWELL;
  localparam int DW   = MAXD > 1 ? $clog2(MAXD) : 1;
  localparam int BW   = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
  typedef enum logic {SHOW_STATE, SHOW_LEVEL} state_t;
  state_t          st_q, st_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_q, blink_d;
  logic [2:0]      prev_q;
  logic [N-1:0]    columns_q, frame;
  logic            showing_q;
  logic [ROWS-1:0] bar;
  logic            auto_mode, wrap;
  genvar r;
  for (r = 0; r < ROWS; r++) begin : g_bar
    assign bar[r] = 32'(water_level) > r;
  end
  assign auto_mode = force_mode == 2'b00 || force_mode == 2'b11;
  assign wrap      = blink_cnt_q == BW'(BLINK_HALF - 1);
  assign frame     = (st_q == SHOW_STATE ? state_image : {COLS{bar}}) & {N{blink_q | ~alarm}};
  // next FSM state and dwell: forcing, then preemption, then dwell expiry
  always_comb begin
    st_d    = st_q;
    dwell_d = dwell_q + 1'b1;
    if (force_mode == 2'b01) begin
      st_d    = SHOW_STATE;
      dwell_d = '0;
    end else if (force_mode == 2'b10) begin
      st_d    = SHOW_LEVEL;
      dwell_d = '0;
    end else if (auto_mode && current_state != prev_q) begin
      st_d    = SHOW_STATE;
      dwell_d = '0;
    end else if (st_q == SHOW_STATE && dwell_q == DW'(STATE_DWELL - 1)) begin
      st_d    = SHOW_LEVEL;
      dwell_d = '0;
    end else if (st_q == SHOW_LEVEL && dwell_q == DW'(LEVEL_DWELL - 1)) begin
      st_d    = SHOW_STATE;
      dwell_d = '0;
    end
  end
  // blink counter only advances during an alarm and restarts in the on phase
  always_comb begin
    blink_cnt_d = alarm ? (wrap ? '0 : blink_cnt_q + 1'b1) : '0;
    blink_d     = alarm ? blink_q ^ wrap : 1'b1;
  end
  // state registers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q        <= SHOW_STATE;
      dwell_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      prev_q      <= current_state;
      columns_q   <= '0;
      showing_q   <= 1'b1;
    end else begin
      st_q        <= st_d;
      dwell_q     <= dwell_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      prev_q      <= current_state;
      columns_q   <= frame;
      showing_q   <= st_q == SHOW_STATE;
    end
  end
  assign columns       = columns_q;
  assign showing_state = showing_q;
endmodule

// File: tb/tb_matrix_display_sequencer.sv
// tb_matrix_display_sequencer: directed checks of alternation, level bar, preemption, forcing, blink and reset
module tb_matrix_display_sequencer;
  localparam logic [34:0] IMG_A = 35'h2AAAAAAAA;
  localparam logic [34:0] IMG_B = 35'h555555555;
  localparam logic [34:0] BAR0  = 35'h0;
  localparam logic [34:0] BAR3  = {5{7'b0000111}};
  localparam logic [34:0] BAR5  = {5{7'b0011111}};
  localparam logic [34:0] BAR7  = {5{7'b1111111}};
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  current_state = 3'd2;
  logic [34:0] state_image = IMG_A;
  logic [2:0]  water_level = 3'd3;
  logic [1:0]  force_mode = 2'b00;
  logic        alarm = 1'b0;
  logic [34:0] columns;
  logic        showing_state;
  int          n_chk = 0;
  int          n_fail = 0;
  matrix_display_sequencer #(
    .COLS(5), .ROWS(7), .LEVEL_W(3),
    .STATE_DWELL(4), .LEVEL_DWELL(3), .BLINK_HALF(2)
  ) dut (
    .clock(clock), .reset(reset), .current_state(current_state),
    .state_image(state_image), .water_level(water_level),
    .force_mode(force_mode), .alarm(alarm),
    .columns(columns), .showing_state(showing_state)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [34:0] exp_c, input logic exp_s);
    n_chk++;
    assert (columns === exp_c) else begin
      n_fail++;
      $error("FAIL %s columns got %h want %h", tag, columns, exp_c);
    end
    n_chk++;
    assert (showing_state === exp_s) else begin
      n_fail++;
      $error("FAIL %s showing_state got %b want %b", tag, showing_state, exp_s);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset", BAR0, 1'b1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    tick();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("auto", (i % 7) < 4 ? IMG_A : BAR3, (i % 7) < 4);
    end
    force_mode = 2'b10;
    water_level = 3'd0;
    do_reset();
    tick();
    tick();
    chk("lvl_empty", BAR0, 1'b0);
    water_level = 3'd7;
    tick();
    chk("lvl_full", BAR7, 1'b0);
    water_level = 3'd3;
    tick();
    chk("lvl3", BAR3, 1'b0);
    water_level = 3'd5;
    chk("lvl_hold", BAR3, 1'b0);
    tick();
    chk("lvl5", BAR5, 1'b0);
    force_mode = 2'b00;
    water_level = 3'd3;
    current_state = 3'd2;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pre_img", IMG_A, 1'b1);
    end
    tick();
    chk("pre_lvl", BAR3, 1'b0);
    current_state = 3'd4;
    tick();
    chk("pre_lvl2", BAR3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pre_dwell", IMG_A, 1'b1);
    end
    current_state = 3'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pre_expiry", IMG_A, 1'b1);
    end
    tick();
    chk("pre_after", BAR3, 1'b0);
    state_image = IMG_B;
    force_mode = 2'b01;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i == 10) current_state = 3'd5;
      tick();
      chk("force01", IMG_B, 1'b1);
    end
    force_mode = 2'b10;
    tick();
    chk("to10_a", IMG_B, 1'b1);
    current_state = 3'd1;
    tick();
    chk("to10_b", BAR3, 1'b0);
    tick();
    chk("to10_c", BAR3, 1'b0);
    force_mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to00_lvl", BAR3, 1'b0);
    end
    tick();
    chk("to00_img", IMG_B, 1'b1);
    state_image = IMG_A;
    force_mode = 2'b01;
    alarm = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("blink", (i % 4) < 2 ? IMG_A : BAR0, 1'b1);
    end
    alarm = 1'b0;
    tick();
    chk("alarm_off", IMG_A, 1'b1);
    tick();
    chk("alarm_off2", IMG_A, 1'b1);
    alarm = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("blink_re", i < 2 ? IMG_A : BAR0, 1'b1);
    end
    force_mode = 2'b00;
    alarm = 1'b0;
    do_reset();
    alarm = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_img", i < 2 ? IMG_A : BAR0, 1'b1);
    end
    tick();
    chk("mr_lvl", BAR3, 1'b0);
    reset = 1'b1;
    tick();
    chk("mr_reset", BAR0, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_dwell", i < 2 ? IMG_A : BAR0, 1'b1);
    end
    tick();
    chk("mr_lvl2", BAR3, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
